// File: rtl/shape_cmd_scheduler.sv
// shape_cmd_scheduler: FIFO-buffered shape opcode dispatcher with completion watchdog and flush
module shape_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     cmd_valid,
  input  logic [95:0]              cmd_data,
  output logic                     cmd_ready,
  output logic [95:0]              full_opcode,
  output logic                     new_shape,
  input  logic                     shape_done,
  input  logic                     flush,
  input  logic                     err_clr,
  output logic                     timeout_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];
  localparam logic [TW-1:0] TMAX = TIMEOUT[TW-1:0];
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [95:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic full, empty, push, pop, expire;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign cmd_ready = !full && !flush;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && !empty && !flush;
  assign expire = state == WAIT && !shape_done && timer == TMAX;
  assign new_shape = state == ISSUE;
  assign busy = state != IDLE || !empty;
  always_comb
    state_nxt = pop ? ISSUE :
                state == ISSUE ? WAIT :
                (state == WAIT && (shape_done || timer == TMAX)) ? IDLE : state;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full_opcode <= '0;
      timer <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count <= flush ? '0 : count + CW'(push) - CW'(pop);
      full_opcode <= pop ? mem[rd_ptr] : full_opcode;
      timer <= state == ISSUE ? '0 : (state == WAIT && timer != TMAX) ? timer + TW'(1) : timer;
      timeout_err <= expire || (timeout_err && !err_clr);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cmd_data;
endmodule

// File: tb/tb_shape_cmd_scheduler.sv
// tb_shape_cmd_scheduler: randomized scoreboard bench against a queue-based reference model
module tb_shape_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [95:0] cmd_data = '0;
  logic shape_done = 1'b0;
  logic flush = 1'b0;
  logic err_clr = 1'b0;
  logic cmd_ready, new_shape, timeout_err, busy;
  logic [95:0] full_opcode;
  logic [$clog2(DEPTH):0] count;
  typedef struct {logic [95:0] op; longint at;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [95:0] mq[$];
  logic [95:0] mop = '0;
  int phase = 0;
  int waited = 0;
  bit merr = 1'b0;
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  shape_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .full_opcode(full_opcode),
    .new_shape(new_shape),
    .shape_done(shape_done),
    .flush(flush),
    .err_clr(err_clr),
    .timeout_err(timeout_err),
    .busy(busy),
    .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic check_outputs();
    chk("count", 96'(count), 96'(mq.size()));
    chk("cmd_ready", 96'(cmd_ready), 96'(mq.size() < DEPTH && !flush));
    chk("busy", 96'(busy), 96'(phase != 0 || mq.size() != 0));
    chk("timeout_err", 96'(timeout_err), 96'(merr));
    chk("full_opcode", full_opcode, mop);
  endtask
  task automatic cycle(bit v, logic [95:0] d, bit done, bit fl, bit clr);
    bit rdy, take;
    @(negedge clk);
    cmd_valid = v;
    cmd_data = d;
    shape_done = done;
    flush = fl;
    err_clr = clr;
    #1 check_outputs();
    rdy = mq.size() < DEPTH && !fl;
    take = phase == 0 && mq.size() > 0 && !fl;
    if (clr) merr = 1'b0;
    if (take) begin
      exp_q.push_back('{mq[0], cyc + 1});
      mop = mq.pop_front();
      phase = 1;
    end else if (phase == 1) begin
      phase = 2;
      waited = 0;
    end else if (phase == 2) begin
      if (done) phase = 0;
      else if (waited == TIMEOUT) begin
        merr = 1'b1;
        phase = 0;
      end else waited++;
    end
    if (fl) mq.delete();
    else if (v && rdy) mq.push_back(d);
  endtask
  task automatic idle(int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    shape_done = 1'b0;
    flush = 1'b0;
    err_clr = 1'b0;
    #3 n_reset = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    phase = 0;
    waited = 0;
    merr = 1'b0;
    mop = '0;
    check_outputs();
    chk("reset_new_shape", 96'(new_shape), 96'(0));
    @(negedge clk);
    n_reset = 1'b1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (new_shape) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL new_shape: got unexpected pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.at != cyc || full_opcode !== mon_e.op) begin
            errors++;
            $display("FAIL issue: got cycle %0d opcode %h, expected cycle %0d opcode %h", cyc, full_opcode, mon_e.at, mon_e.op);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_issue: got no pulse at cycle %0d, expected opcode %h", cyc, exp_q[0].op);
        exp_q.pop_front();
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "bench time limit");
  end
  initial begin
    #12;
    check_outputs();
    chk("reset_new_shape", 96'(new_shape), 96'(0));
    @(negedge clk);
    n_reset = 1'b1;
    cycle(1'b1, 96'hA5A5A5A5_A5A5A5A5_A5A5A501, 1'b0, 1'b0, 1'b0);
    idle(6);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    idle(3);
    repeat (16) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
      idle(3);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    idle(2);
    cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    idle(20);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (30) cycle(1'b0, '0, phase == 2 && waited == TIMEOUT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, rnd96(), 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(5);
    cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    repeat (30) cycle(1'b0, '0, 1'b0, 1'b0, phase == 2 && waited == TIMEOUT);
    idle(2);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    idle(2);
    do_reset();
    cycle(1'b1, rnd96(), 1'b0, 1'b0, 1'b0);
    idle(4);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 600) == 0) do_reset();
      cycle($urandom_range(0, 2) == 0, rnd96(), $urandom_range(0, 7) == 0,
            $urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0);
    end
    repeat (40) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("scoreboard_drain", 96'(exp_q.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
